rr_encoder_arbiter: RTL and testbench
=====================================

Name: rr_encoder_arbiter

Overview:
- Round-robin arbiter sharing one 4-to-2 encoded resource among four requesters.
- Grants one requester at a time and drives a one-hot grant plus its 2-bit binary index, the same encoding the 4x2 encoder produces.
- Holds each grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits between requester logic and the shared encoder/datapath consumer.

Parameters:
- MAX_HOLD, 8, max consecutive cycles a grant may be held; 0 disables the timeout.
- HOLD_W, 4, hold counter width; MAX_HOLD must be < 2^HOLD_W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit i belongs to requester i.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- grant  output  4  one-hot grant, registered.
- grant_idx  output  2  binary index of the granted requester (0001->00, 0010->01, 0100->10, 1000->11); 00 when idle.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (sampled at clk edge, rst=1):
  - grant=0000, grant_idx=00, grant_valid=0, timeout=0.
  - state=IDLE, hold counter=0, priority pointer ptr=0.
  - rst overrides all other inputs, including mid-grant.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit searching ptr, ptr+1, ... modulo 4.
  - At the next edge: grant=onehot(sel), grant_idx=sel, grant_valid=1, counter=0, state=GRANT.
  - Latency from req sampled to grant is one cycle.
  - If req==0, stay in IDLE with outputs 0.
- GRANT:
  - grant, grant_idx and grant_valid are stable. Requests from non-owners are ignored.
  - Release conditions, evaluated each cycle: (a) done=1; (b) req[owner]=0; (c) MAX_HOLD!=0 and counter==MAX_HOLD-1.
  - On release, at the next edge: grant=0000, grant_idx=00, grant_valid=0, ptr=(owner+1) mod 4, counter=0, state=IDLE.
  - If none of the release conditions holds, the counter increments.
  - A grant therefore lasts at most MAX_HOLD cycles.
- Mandatory one-cycle idle gap between consecutive grants (IDLE always has at least one cycle with grant_valid=0), even for the same requester.
- timeout:
  - Asserted for exactly one cycle, coincident with the first grant_valid=0 cycle after a release caused only by (c).
  - If (a) or (b) occurs in the same cycle as (c), the release is normal and timeout stays 0.
- ptr advances only on release, never on reset-abort; reset returns ptr to 0.
- With MAX_HOLD=0 the counter saturates at 2^HOLD_W-1 and never forces release.
- Invariants:
  - grant is always 0000 or one-hot.
  - grant_idx always equals the encoding of grant.
  - grant_valid = |grant.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> grant=0000, grant_idx=00, grant_valid=0, timeout=0 throughout.
- Single requester: req=0100 from cycle k; done=1 for one cycle at k+3 -> grant=0100 and grant_idx=10 at k+1..k+3; grant=0000 at k+4; regrant of 0100 at k+5.
- Round robin: req=1111 held; done pulsed in the first cycle of each grant -> grant sequence 0001, 0010, 0100, 1000, 0001 with grant_idx 00, 01, 10, 11, 00, each separated by one idle cycle.
- Timeout: MAX_HOLD=8, req=0010 held, done=0 -> grant_valid high exactly 8 cycles; timeout=1 for one cycle in the first idle cycle; grant_idx=01 again after the gap.
- Done/timeout collision: MAX_HOLD=8, done=1 in the 8th grant cycle -> grant drops at the same edge as a pure timeout would; timeout stays 0.
- Reset mid-grant and ptr restore: grant=1000 active; rst=1 for one cycle -> grant=0000 next edge; then req=1001 -> grant=0001 (ptr=0), not 1000.

Source files
------------

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4-to-2 encoded resource.
// Grants are registered one-hot with a matching 2-bit index. A grant is held
// until the owner asserts done, drops its request, or reaches the hold limit.
// A one-cycle idle gap separates any two grants.
module rr_encoder_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        ptr;
  logic [1:0]        ptr_nxt;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_nxt;
  logic [3:0]        grant_nxt;
  logic [1:0]        idx_nxt;
  logic              valid_nxt;
  logic              timeout_nxt;

  logic [1:0]        sel;
  logic [1:0]        cand;
  logic              found;

  logic              rel_done;
  logic              rel_drop;
  logic              rel_hold;
  logic              release_now;

  // Rotating priority search: first set request at ptr, ptr+1, ... mod 4.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Release conditions for the current owner (meaningful only in GRANT).
  always_comb begin
    rel_done    = done;
    rel_drop    = ~req[grant_idx];
    rel_hold    = HOLD_EN && (cnt == HOLD_LAST);
    release_now = rel_done | rel_drop | rel_hold;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    grant_nxt   = grant;
    idx_nxt     = grant_idx;
    valid_nxt   = grant_valid;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (found) begin
          state_nxt = GRANT;
          grant_nxt = 4'b0001 << sel;
          idx_nxt   = sel;
          valid_nxt = 1'b1;
        end else begin
          grant_nxt = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          cnt_nxt     = '0;
          ptr_nxt     = grant_idx + 2'd1;
          // Timeout is flagged only when the hold limit alone forced release.
          timeout_nxt = rel_hold & ~rel_done & ~rel_drop;
        end else begin
          // Saturate so a disabled limit never wraps the counter.
          cnt_nxt = (cnt == '1) ? cnt : cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter with MAX_HOLD=8.
module tb_rr_encoder_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int errors;
  int checks;

  rr_encoder_arbiter #(
    .MAX_HOLD(8),
    .HOLD_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                         input logic ev, input logic et);
    chk({tag, ".grant"},   8'(grant),       8'(eg));
    chk({tag, ".idx"},     8'(grant_idx),   8'(ei));
    chk({tag, ".valid"},   8'(grant_valid), 8'(ev));
    chk({tag, ".timeout"}, 8'(timeout),     8'(et));
  endtask

  logic [3:0] rr_seq [5];
  logic [1:0] rr_idx [5];

  initial begin
    errors = 0;
    checks = 0;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset with all requests asserted.
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    step();
    chk_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b0000;
    step();
    chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2 with done on the third grant cycle.
    req = 4'b0100;
    step();
    chk_out("single_k1", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk_out("single_k2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk_out("single_k3", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_out("single_k4_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("single_k5_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("single_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset restores ptr to 0 before the round-robin sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Round robin with done in the first cycle of every grant.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("rr_grant%0d", i), rr_seq[i], rr_idx[i], 1'b1, 1'b0);
      done = 1'b1;
      step();
      done = 1'b0;
      chk_out($sformatf("rr_gap%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    // ptr is now 1.

    // Timeout: requester 1 holds without done for the full limit.
    req = 4'b0010;
    step();
    chk_out("to_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk_out($sformatf("to_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    chk_out("to_gap", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_out("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Done collides with the hold limit on the 8th grant cycle.
    for (int c = 2; c <= 8; c++) begin
      step();
    end
    chk_out("coll_c8", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_out("coll_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    // ptr is now 2.

    // Reset mid-grant, then ptr must be back at 0.
    req = 4'b1000;
    step();
    chk_out("rm_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    step();
    chk_out("rm_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("rm_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1001;
    step();
    chk_out("rm_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
